// File: rtl/score_keeper_pkg.sv
// score_keeper_pkg
//   Shared definitions for the game-flow slice: state codes, bit positions
//   inside the packed game_state word, and the score bus width. The display
//   stage and the ball engine import this same package so that all three
//   agree on the encoding.
package score_keeper_pkg;

  localparam int SCORE_W    = 16;
  localparam int STATE_W    = 3;
  localparam int STATE_LSB  = 0;
  localparam int SERVER_BIT = 8;
  localparam int WINNER_BIT = 9;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

endpackage

// File: rtl/score_keeper_button_pulse.sv
// button_pulse
//   Turns a raw asynchronous push button into a single-cycle pulse on its
//   rising edge: two-flop synchronizer, one history flop, registered edge
//   detect. The pulse appears 3 clocks after the button rises.
// Ports:
//   clk   - system clock
//   rst   - asynchronous, active-low reset (clears every flop)
//   btn   - raw button level, unsynchronized
//   pulse - one-cycle pulse per rising edge of btn
module button_pulse (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic       sync_1;
  logic       sync_2;
  logic       sync_3;
  logic [2:0] primed;

  // The synchronizer stages reset to 0, which is not a real sample of the
  // button. A button already held high across reset release would otherwise
  // look like a rising edge, so edges are only reported once every stage
  // holds a value genuinely sampled after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
      primed <= 3'b000;
      pulse  <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
      primed <= {primed[1:0], 1'b1};
      pulse  <= sync_2 & ~sync_3 & primed[2];
    end
  end

endmodule

// File: rtl/score_keeper.sv
// score_keeper
//   Game-flow controller: owns both scores, the server/winner flags and the
//   game state, and runs the serve handshake toward the ball engine.
// Ports:
//   clk, rst     - system clock, asynchronous active-low reset
//   frame_tick   - one pulse per video frame (paces the post-point pause)
//   start_btn    - raw start button
//   miss_you     - ball passed your paddle (point to them)
//   miss_them    - ball passed their paddle (point to you)
//   serve_ack    - ball engine accepted the serve
//   serve_req    - asking the ball engine to launch a serve
//   your_score   - your score, zero-extended binary
//   their_score  - their score, zero-extended binary
//   game_state   - [2:0] state, [8] server (1=you), [9] winner (1=you)
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               miss_you,
  input  logic               miss_them,
  input  logic               serve_ack,
  output logic               serve_req,
  output logic [SCORE_W-1:0] your_score,
  output logic [SCORE_W-1:0] their_score,
  output logic [SCORE_W-1:0] game_state
);

  localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);
  localparam logic [7:0] PAUSE_VAL = 8'(PAUSE_FRAMES);

  logic        start;
  game_state_t state_q, state_d;
  logic [3:0]  your_q, your_d;
  logic [3:0]  their_q, their_d;
  logic        server_q, server_d;
  logic        winner_q, winner_d;
  logic [7:0]  pause_q, pause_d;
  logic        serve_req_q, serve_req_d;

  button_pulse u_start (
    .clk   (clk),
    .rst   (rst),
    .btn   (start_btn),
    .pulse (start)
  );

  // Next-state logic. Everything holds by default; each state only touches
  // what it owns. Counter is cleared on the edge that enters PAUSE, so a
  // frame tick coinciding with the scoring miss is never counted.
  always_comb begin
    state_d  = state_q;
    your_d   = your_q;
    their_d  = their_q;
    server_d = server_q;
    winner_d = winner_q;
    pause_d  = pause_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          your_d   = 4'd0;
          their_d  = 4'd0;
          winner_d = 1'b0;
          server_d = 1'b1;
          state_d  = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (serve_ack) begin
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (miss_you && miss_them) begin
          state_d = ST_PAUSE;
          pause_d = 8'd0;
        end else if (miss_them) begin
          your_d   = (your_q >= WIN_VAL) ? WIN_VAL : your_q + 4'd1;
          server_d = 1'b0;
          pause_d  = 8'd0;
          if (your_d == WIN_VAL) begin
            state_d  = ST_OVER;
            winner_d = 1'b1;
          end else begin
            state_d = ST_PAUSE;
          end
        end else if (miss_you) begin
          their_d  = (their_q >= WIN_VAL) ? WIN_VAL : their_q + 4'd1;
          server_d = 1'b1;
          pause_d  = 8'd0;
          if (their_d == WIN_VAL) begin
            state_d  = ST_OVER;
            winner_d = 1'b0;
          end else begin
            state_d = ST_PAUSE;
          end
        end
      end

      ST_PAUSE: begin
        if (frame_tick) begin
          pause_d = pause_q + 8'd1;
          if (pause_d == PAUSE_VAL) begin
            state_d = ST_SERVE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Request is registered from the next state so it rises on entry to
    // SERVE and falls on the same edge that moves to PLAY.
    serve_req_d = (state_d == ST_SERVE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      your_q      <= 4'd0;
      their_q     <= 4'd0;
      server_q    <= 1'b1;
      winner_q    <= 1'b0;
      pause_q     <= 8'd0;
      serve_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      your_q      <= your_d;
      their_q     <= their_d;
      server_q    <= server_d;
      winner_q    <= winner_d;
      pause_q     <= pause_d;
      serve_req_q <= serve_req_d;
    end
  end

  // Pack registered state into the display-facing words.
  always_comb begin
    game_state                         = '0;
    game_state[STATE_LSB +: STATE_W]   = state_q;
    game_state[SERVER_BIT]             = server_q;
    game_state[WINNER_BIT]             = winner_q;
  end

  assign your_score  = {{(SCORE_W-4){1'b0}}, your_q};
  assign their_score = {{(SCORE_W-4){1'b0}}, their_q};
  assign serve_req   = serve_req_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper
//   Self-checking bench for score_keeper. A behavioural game model (scores as
//   integers, button history as a queue of samples) predicts every output
//   after every clock edge; directed phases walk the documented scenarios and
//   a randomized phase exercises the rest.
module tb_score_keeper;

  localparam int WIN   = 9;
  localparam int PAUSE = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start_btn = 1'b0;
  logic        miss_you = 1'b0;
  logic        miss_them = 1'b0;
  logic        serve_ack = 1'b0;
  logic        serve_req;
  logic [15:0] your_score;
  logic [15:0] their_score;
  logic [15:0] game_state;

  int errCount   = 0;
  int checkCount = 0;

  // Reference model state: 0 idle, 1 serve, 2 play, 3 pause, 4 over
  int mMode;
  int mYou;
  int mThem;
  int mCnt;
  bit mServer;
  bit mWinner;
  bit btnHist[$];

  score_keeper #(
    .WIN_SCORE    (WIN),
    .PAUSE_FRAMES (PAUSE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start_btn   (start_btn),
    .miss_you    (miss_you),
    .miss_them   (miss_them),
    .serve_ack   (serve_ack),
    .serve_req   (serve_req),
    .your_score  (your_score),
    .their_score (their_score),
    .game_state  (game_state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mMode   = 0;
    mYou    = 0;
    mThem   = 0;
    mCnt    = 0;
    mServer = 1'b1;
    mWinner = 1'b0;
    btnHist.delete();
  endtask

  function automatic logic [15:0] expGameState();
    return 16'(mMode) | (16'(mServer) << 8) | (16'(mWinner) << 9);
  endfunction

  // Start fires at edge n when the button sample taken at edge n-3 is high
  // and the sample at edge n-4 was low, both taken after reset release.
  task automatic modelStep(input bit btn, input bit mu, input bit mt, input bit ack, input bit tick);
    int n;
    bit start;
    n = btnHist.size() + 1;
    start = 1'b0;
    if (n >= 5) start = btnHist[n-4] && !btnHist[n-5];
    btnHist.push_back(btn);
    case (mMode)
      0, 4: if (start) begin
        mYou = 0; mThem = 0; mWinner = 1'b0; mServer = 1'b1; mMode = 1;
      end
      1: if (ack) mMode = 2;
      2: begin
        if (mu && mt) begin
          mMode = 3; mCnt = 0;
        end else if (mt) begin
          mYou = (mYou < WIN) ? mYou + 1 : WIN;
          mServer = 1'b0;
          if (mYou == WIN) begin mMode = 4; mWinner = 1'b1; end
          else begin mMode = 3; mCnt = 0; end
        end else if (mu) begin
          mThem = (mThem < WIN) ? mThem + 1 : WIN;
          mServer = 1'b1;
          if (mThem == WIN) begin mMode = 4; mWinner = 1'b0; end
          else begin mMode = 3; mCnt = 0; end
        end
      end
      3: if (tick) begin
        mCnt++;
        if (mCnt == PAUSE) mMode = 1;
      end
      default: mMode = 0;
    endcase
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, "_you"},   your_score,  16'(mYou));
    checkOutput({tag, "_them"},  their_score, 16'(mThem));
    checkOutput({tag, "_state"}, game_state,  expGameState());
    checkOutput({tag, "_req"},   {15'b0, serve_req}, 16'(mMode == 1));
  endtask

  // Called at a negative edge: drive inputs, let one rising edge happen,
  // check 1 ns later, return at the next negative edge.
  task automatic applyStimulus(input string tag, input bit btn, input bit mu, input bit mt,
                               input bit ack, input bit tick);
    start_btn  = btn;
    miss_you   = mu;
    miss_them  = mt;
    serve_ack  = ack;
    frame_tick = tick;
    @(posedge clk);
    if (rst) modelStep(btn, mu, mt, ack, tick);
    #1;
    compareAll(tag);
    @(negedge clk);
  endtask

  initial begin
    bit btnLevel;

    // Reset held from time zero
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rst_you",   your_score,  16'h0000);
    checkOutput("rst_them",  their_score, 16'h0000);
    checkOutput("rst_state", game_state,  16'h0100);
    checkOutput("rst_req",   {15'b0, serve_req}, 16'h0000);
    rst = 1'b1;

    // Idle, no stimulus
    for (int i = 0; i < 100; i++) applyStimulus("idle", 0, 0, 0, 0, 0);
    checkOutput("idle_gs", game_state, 16'h0100);

    // Start button: SERVE after the fourth edge with the button high
    for (int i = 0; i < 3; i++) begin
      applyStimulus("startwait", 1, 0, 0, 0, 0);
      checkOutput("startwait_code", {13'b0, game_state[2:0]}, 16'd0);
    end
    applyStimulus("start", 1, 0, 0, 0, 0);
    checkOutput("start_code", {13'b0, game_state[2:0]}, 16'd1);
    checkOutput("start_req",  {15'b0, serve_req}, 16'd1);

    applyStimulus("ack", 1, 0, 0, 1, 0);
    checkOutput("ack_code", {13'b0, game_state[2:0]}, 16'd2);
    checkOutput("ack_req",  {15'b0, serve_req}, 16'd0);

    applyStimulus("miss_them", 1, 0, 1, 0, 0);
    checkOutput("pt_you", your_score, 16'd1);
    checkOutput("pt_gs",  game_state, 16'h0003);

    // Pause: 59 ticks keep it in PAUSE, the 60th returns to SERVE
    applyStimulus("pause0", 1, 0, 0, 0, 0);
    for (int i = 0; i < PAUSE - 1; i++) applyStimulus("pause", 1, 0, 0, 0, 1);
    checkOutput("pause59_code", {13'b0, game_state[2:0]}, 16'd3);
    applyStimulus("pause60", 1, 0, 0, 0, 1);
    checkOutput("pause60_code", {13'b0, game_state[2:0]}, 16'd1);

    // Let: both misses together
    applyStimulus("ack2", 1, 0, 0, 1, 0);
    applyStimulus("let", 1, 1, 1, 0, 0);
    checkOutput("let_you",  your_score,  16'd1);
    checkOutput("let_them", their_score, 16'd0);
    checkOutput("let_gs",   game_state,  16'h0003);

    // Run you up to the winning score
    for (int p = 0; p < 20 && mYou < WIN; p++) begin
      applyStimulus("run_p0", 1, 0, 0, 0, 0);
      for (int i = 0; i < PAUSE; i++) applyStimulus("run_pause", 1, 0, 0, 0, 1);
      applyStimulus("run_ack", 1, 0, 0, 1, 0);
      applyStimulus("run_pt", 1, 0, 1, 0, 0);
    end
    checkOutput("win_you", your_score, 16'd9);
    checkOutput("win_gs",  game_state, 16'h0204);

    // Over: misses ignored
    applyStimulus("over_mt", 1, 0, 1, 0, 1);
    applyStimulus("over_mu", 1, 1, 0, 0, 1);
    checkOutput("over_you", your_score, 16'd9);

    // Restart from OVER
    applyStimulus("rs_low", 0, 0, 0, 0, 0);
    applyStimulus("rs_low", 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus("rs_high", 1, 0, 0, 0, 0);
    checkOutput("restart_you", your_score, 16'd0);
    checkOutput("restart_gs",  game_state, 16'h0101);

    // Into PAUSE and 30 ticks, then reset mid-pause
    applyStimulus("mr_ack", 1, 0, 0, 1, 0);
    applyStimulus("mr_pt", 1, 1, 0, 0, 0);
    checkOutput("mr_them", their_score, 16'd1);
    checkOutput("mr_gs",   game_state,  16'h0103);
    applyStimulus("mr_p0", 1, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) applyStimulus("mr_pause", 1, 0, 0, 0, 1);
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("arst_you",   your_score,  16'h0000);
    checkOutput("arst_them",  their_score, 16'h0000);
    checkOutput("arst_state", game_state,  16'h0100);
    checkOutput("arst_req",   {15'b0, serve_req}, 16'h0000);
    @(posedge clk);
    #1;
    compareAll("arst_hold");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus("post_rst", 1, 0, 0, 0, 0);
    checkOutput("post_rst_gs", game_state, 16'h0100);

    // Randomized play
    btnLevel = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 31) == 0) btnLevel = ~btnLevel;
      applyStimulus("rand", btnLevel,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
